// File: rtl/pipe_rx_os_pkg.sv
// Shared symbol codes, decoder FSM encoding and TS field layout for the Rx ordered-set decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pipe_rx_os_pkg;

    // 8b/10b control and data symbols seen in Gen1 ordered sets
    localparam logic [7:0] K_COM    = 8'hBC;
    localparam logic [7:0] K_PAD    = 8'hF7;
    localparam logic [7:0] K_SKP    = 8'h1C;
    localparam logic [7:0] K_IDL    = 8'h7C;
    localparam logic [7:0] D_TS1_ID = 8'h4A;
    localparam logic [7:0] D_TS2_ID = 8'h45;

    // Symbol index within an OS; COM is symbol 0, the last TS identifier is symbol 15
    localparam int IDX_W    = 4;
    localparam int OS_LAST  = 15;

    // TS field widths
    localparam int FIELD_W  = 8;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SKIP    = 2'd2
    } os_state_t;

    // Everything that must match for two TSs to count as identical
    typedef struct packed {
        logic               ts_type;   // 0 = TS1, 1 = TS2
        logic [FIELD_W-1:0] link;
        logic               link_pad;
        logic [FIELD_W-1:0] lane;
        logic               lane_pad;
        logic [FIELD_W-1:0] nfts;
        logic [FIELD_W-1:0] rate;
        logic [FIELD_W-1:0] ctrl;
    } ts_fields_t;

    localparam int TS_FIELDS_W = $bits(ts_fields_t);

endpackage

// File: rtl/os_consec_counter.sv
// Compares each good TS against the previously stored one and keeps a saturating run length.
// Latency: count updates on the same edge that registers the ts_valid pulse.
// Backpressure: none; an update is accepted whenever upd is high.
module os_consec_counter
    import pipe_rx_os_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             err,
    input  logic             upd,
    input  ts_fields_t       new_ts,
    output logic [CNT_W-1:0] cnt
);

    ts_fields_t       prev_ts;
    logic             prev_vld;
    logic             same;
    logic [CNT_W-1:0] cnt_max;

    assign cnt_max = '1;
    assign same    = prev_vld && (new_ts == prev_ts);

    // Clear (idle/gen change) forgets history; an error only breaks the run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            prev_ts  <= '0;
            prev_vld <= 1'b0;
        end else if (clear) begin
            cnt      <= '0;
            prev_vld <= 1'b0;
        end else if (err) begin
            cnt      <= '0;
        end else if (upd) begin
            if (!same)
                cnt <= CNT_W'(1);
            else if (cnt != cnt_max)
                cnt <= cnt + 1'b1;
            prev_ts  <= new_ts;
            prev_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_rx_os_decoder.sv
// Frames Gen1 ordered sets on COM, validates and decodes TS1/TS2, flags SKP OS, EIOS and malformed OSs.
// Latency: every pulse is registered, 1 cycle after the deciding symbol is sampled.
// Backpressure: none; symbols are consumed on every in_valid cycle, bubbles hold all state.
module pipe_rx_os_decoder
    import pipe_rx_os_pkg::*;
#(
    parameter int GEN_ACTIVE = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       GEN,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_datak,
    input  logic             in_elec_idle,
    output logic             ts_valid,
    output logic             ts_type,
    output logic [7:0]       ts_link,
    output logic             ts_link_pad,
    output logic [7:0]       ts_lane,
    output logic             ts_lane_pad,
    output logic [7:0]       ts_nfts,
    output logic [7:0]       ts_rate,
    output logic [7:0]       ts_ctrl,
    output logic [CNT_W-1:0] ts_consec_cnt,
    output logic             skp_seen,
    output logic             eios_seen,
    output logic             os_error
);

    os_state_t        state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    ts_fields_t       cap, cap_nxt;
    ts_fields_t       out_ts;
    logic             flush;
    logic             good_ts, err_ev, skp_ev, eios_ev;
    logic             is_com, is_pad, is_skp, is_idl;
    logic [7:0]       ts_id;

    // Idle or a foreign generation abandons any OS in flight
    assign flush  = in_elec_idle || (GEN != 3'(GEN_ACTIVE));
    assign is_com = in_datak && (in_data == K_COM);
    assign is_pad = in_datak && (in_data == K_PAD);
    assign is_skp = in_datak && (in_data == K_SKP);
    assign is_idl = in_datak && (in_data == K_IDL);
    assign ts_id  = cap.ts_type ? D_TS2_ID : D_TS1_ID;

    // State, symbol index and partial-TS capture registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_HUNT;
            idx   <= '0;
            cap   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cap   <= cap_nxt;
        end
    end

    // Next state, field capture and event decode for the current symbol
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cap_nxt   = cap;
        good_ts   = 1'b0;
        err_ev    = 1'b0;
        skp_ev    = 1'b0;
        eios_ev   = 1'b0;
        if (flush) begin
            state_nxt = ST_HUNT;
        end else if (in_valid) begin
            case (state)
                ST_HUNT: begin
                    if (is_com) begin
                        state_nxt = ST_COLLECT;
                        idx_nxt   = IDX_W'(1);
                    end
                end
                ST_SKIP: begin
                    if (is_com) begin
                        state_nxt = ST_COLLECT;
                        idx_nxt   = IDX_W'(1);
                    end else if (!is_skp) begin
                        state_nxt = ST_HUNT;
                    end
                end
                default: begin
                    if (is_com) begin
                        // A new COM mid-OS aborts the old one and starts framing the new one
                        err_ev  = 1'b1;
                        idx_nxt = IDX_W'(1);
                    end else begin
                        case (idx)
                            4'd1: begin
                                if (is_skp) begin
                                    skp_ev    = 1'b1;
                                    state_nxt = ST_SKIP;
                                end else if (is_idl) begin
                                    eios_ev   = 1'b1;
                                    state_nxt = ST_HUNT;
                                end else if (in_datak && !is_pad) begin
                                    err_ev = 1'b1;
                                end else begin
                                    cap_nxt.link     = in_data;
                                    cap_nxt.link_pad = is_pad;
                                end
                            end
                            4'd2: begin
                                if (in_datak && !is_pad) begin
                                    err_ev = 1'b1;
                                end else begin
                                    cap_nxt.lane     = in_data;
                                    cap_nxt.lane_pad = is_pad;
                                end
                            end
                            4'd3: if (in_datak) err_ev = 1'b1; else cap_nxt.nfts = in_data;
                            4'd4: if (in_datak) err_ev = 1'b1; else cap_nxt.rate = in_data;
                            4'd5: if (in_datak) err_ev = 1'b1; else cap_nxt.ctrl = in_data;
                            4'd6: begin
                                if (!in_datak && in_data == D_TS1_ID)
                                    cap_nxt.ts_type = 1'b0;
                                else if (!in_datak && in_data == D_TS2_ID)
                                    cap_nxt.ts_type = 1'b1;
                                else
                                    err_ev = 1'b1;
                            end
                            default: begin
                                if (in_datak || in_data != ts_id)
                                    err_ev = 1'b1;
                                else if (idx == IDX_W'(OS_LAST))
                                    good_ts = 1'b1;
                            end
                        endcase
                        if (err_ev || good_ts)
                            state_nxt = ST_HUNT;
                        else if (state_nxt == ST_COLLECT)
                            idx_nxt = idx + 1'b1;
                    end
                end
            endcase
        end
    end

    // Registered event pulses; decoded fields only change on a good TS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_valid  <= 1'b0;
            skp_seen  <= 1'b0;
            eios_seen <= 1'b0;
            os_error  <= 1'b0;
            out_ts    <= '0;
        end else begin
            ts_valid  <= good_ts;
            skp_seen  <= skp_ev;
            eios_seen <= eios_ev;
            os_error  <= err_ev;
            if (good_ts)
                out_ts <= cap;
        end
    end

    assign ts_type     = out_ts.ts_type;
    assign ts_link     = out_ts.link;
    assign ts_link_pad = out_ts.link_pad;
    assign ts_lane     = out_ts.lane;
    assign ts_lane_pad = out_ts.lane_pad;
    assign ts_nfts     = out_ts.nfts;
    assign ts_rate     = out_ts.rate;
    assign ts_ctrl     = out_ts.ctrl;

    os_consec_counter #(.CNT_W(CNT_W)) u_consec (
        .clk    (clk),
        .reset  (reset),
        .clear  (flush),
        .err    (err_ev),
        .upd    (good_ts),
        .new_ts (cap),
        .cnt    (ts_consec_cnt)
    );

endmodule

// File: tb/tb_pipe_rx_os_decoder.sv
// Directed-vector bench for pipe_rx_os_decoder with an OS-level reference model checked every cycle.
// Latency: model predicts registered outputs for the edge that sampled each symbol.
// Backpressure: none exercised; the DUT has no ready.
module tb_pipe_rx_os_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] GEN = 3'd1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_datak = 1'b0;
    logic       in_elec_idle = 1'b0;
    logic       ts_valid, ts_type, ts_link_pad, ts_lane_pad;
    logic [7:0] ts_link, ts_lane, ts_nfts, ts_rate, ts_ctrl;
    logic [3:0] ts_consec_cnt;
    logic       skp_seen, eios_seen, os_error;

    pipe_rx_os_decoder #(.GEN_ACTIVE(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .GEN(GEN), .in_valid(in_valid), .in_data(in_data),
        .in_datak(in_datak), .in_elec_idle(in_elec_idle), .ts_valid(ts_valid), .ts_type(ts_type),
        .ts_link(ts_link), .ts_link_pad(ts_link_pad), .ts_lane(ts_lane), .ts_lane_pad(ts_lane_pad),
        .ts_nfts(ts_nfts), .ts_rate(ts_rate), .ts_ctrl(ts_ctrl), .ts_consec_cnt(ts_consec_cnt),
        .skp_seen(skp_seen), .eios_seen(eios_seen), .os_error(os_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_tsv = 0, n_skp = 0, n_eios = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: works on the buffered OS, not symbol-by-symbol state ----------------
    int          m_mode;        // 0 hunting, 1 inside an OS, 2 inside a SKP OS
    logic [7:0]  q_d[$];
    logic        q_k[$];
    logic        e_tsv, e_skp, e_eios, e_err;
    int          e_cnt;
    logic [42:0] e_f, prev_f;
    bit          prev_ok;
    int          verdict;

    // Judge the symbols after COM seen so far: 0 incomplete, 1 good TS, 2 malformed, 3 SKP OS, 4 EIOS
    function automatic int classify();
        for (int i = 0; i < q_d.size(); i++) begin
            if (i < 2) begin
                if (i == 0 && q_k[0] && q_d[0] == 8'h1C) return 3;
                if (i == 0 && q_k[0] && q_d[0] == 8'h7C) return 4;
                if (q_k[i] && q_d[i] != 8'hF7) return 2;
            end else if (i < 5) begin
                if (q_k[i]) return 2;
            end else if (i == 5) begin
                if (q_k[i] || (q_d[i] != 8'h4A && q_d[i] != 8'h45)) return 2;
            end else if (q_k[i] || q_d[i] != q_d[5]) begin
                return 2;
            end
        end
        return (q_d.size() == 15) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        e_tsv = 1'b0; e_skp = 1'b0; e_eios = 1'b0; e_err = 1'b0;
        if (!reset) begin
            m_mode = 0; q_d.delete(); q_k.delete();
            e_cnt = 0; e_f = '0; prev_f = '0; prev_ok = 1'b0;
        end else if (in_elec_idle || GEN != 3'd1) begin
            m_mode = 0; q_d.delete(); q_k.delete();
            e_cnt = 0; prev_ok = 1'b0;
        end else if (in_valid) begin
            if (m_mode == 0) begin
                if (in_datak && in_data == 8'hBC) begin m_mode = 1; q_d.delete(); q_k.delete(); end
            end else if (m_mode == 2) begin
                if (in_datak && in_data == 8'hBC) begin m_mode = 1; q_d.delete(); q_k.delete(); end
                else if (!(in_datak && in_data == 8'h1C)) m_mode = 0;
            end else if (in_datak && in_data == 8'hBC) begin
                e_err = 1'b1; e_cnt = 0; q_d.delete(); q_k.delete();
            end else begin
                q_d.push_back(in_data); q_k.push_back(in_datak);
                verdict = classify();
                if (verdict == 1) begin
                    e_tsv = 1'b1;
                    e_f = {q_d[5] == 8'h45, q_d[0], q_k[0], q_d[1], q_k[1], q_d[2], q_d[3], q_d[4]};
                    if (prev_ok && prev_f == e_f) e_cnt = (e_cnt < 15) ? e_cnt + 1 : 15;
                    else e_cnt = 1;
                    prev_f = e_f; prev_ok = 1'b1; m_mode = 0;
                end else if (verdict == 2) begin
                    e_err = 1'b1; e_cnt = 0; m_mode = 0;
                end else if (verdict == 3) begin
                    e_skp = 1'b1; m_mode = 2;
                end else if (verdict == 4) begin
                    e_eios = 1'b1; m_mode = 0;
                end
            end
        end
        #1;
        chk("ts_valid", 64'(ts_valid), 64'(e_tsv));
        chk("skp_seen", 64'(skp_seen), 64'(e_skp));
        chk("eios_seen", 64'(eios_seen), 64'(e_eios));
        chk("os_error", 64'(os_error), 64'(e_err));
        chk("consec_cnt", 64'(ts_consec_cnt), 64'(e_cnt));
        chk("fields", 64'({ts_type, ts_link, ts_link_pad, ts_lane, ts_lane_pad, ts_nfts, ts_rate, ts_ctrl}), 64'(e_f));
        if (ts_valid)  n_tsv++;
        if (skp_seen)  n_skp++;
        if (eios_seen) n_eios++;
        if (os_error)  n_err++;
    end

    // ---------------- stimulus ----------------
    task automatic sym(input logic [7:0] d, input logic k);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_datak = k;
    endtask

    task automatic bub(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // COM + 15 symbols; bad_pos (1..15) replaces that symbol with bad_sym as data
    task automatic send_ts(input logic [7:0] lnk, input logic lnk_k, input logic [7:0] ln, input logic ln_k,
                           input logic [7:0] id, input int gap, input int bad_pos, input logic [7:0] bad_sym);
        logic [7:0] d;
        logic       k;
        sym(8'hBC, 1'b1);
        for (int i = 1; i < 16; i++) begin
            bub(gap);
            k = 1'b0;
            case (i)
                1:       begin d = lnk; k = lnk_k; end
                2:       begin d = ln;  k = ln_k;  end
                3:       d = 8'h20;
                4:       d = 8'h02;
                5:       d = 8'h00;
                default: d = id;
            endcase
            if (i == bad_pos) begin d = bad_sym; k = 1'b0; end
            sym(d, k);
        end
    endtask

    // Look just after the edge that sampled the last symbol, then stop driving
    task automatic after_ts(input string name, input logic exp_vld);
        @(posedge clk);
        #2;
        chk(name, 64'(ts_valid), 64'(exp_vld));
        in_valid = 1'b0;
    endtask

    int base;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_cnt", 64'(ts_consec_cnt), 64'd0);
        chk("reset_pulses", 64'({ts_valid, skp_seen, eios_seen, os_error}), 64'd0);
        chk("reset_link", 64'(ts_link), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bub(2);

        // 1: eight identical TS1 back to back
        for (int n = 0; n < 8; n++) begin
            send_ts(8'h00, 1'b0, 8'h03, 1'b0, 8'h4A, 0, 0, 8'h00);
            after_ts("t1_pulse", 1'b1);
            chk("t1_cnt", 64'(ts_consec_cnt), 64'(n + 1));
        end
        chk("t1_npulse", 64'(n_tsv), 64'd8);
        chk("t1_type", 64'(ts_type), 64'd0);
        chk("t1_lane", 64'(ts_lane), 64'h03);
        chk("t1_nfts", 64'(ts_nfts), 64'h20);
        chk("t1_rate", 64'(ts_rate), 64'h02);

        // 2: TS2 with PAD link and lane
        send_ts(8'hF7, 1'b1, 8'hF7, 1'b1, 8'h45, 0, 0, 8'h00);
        after_ts("t2_pulse", 1'b1);
        chk("t2_type", 64'(ts_type), 64'd1);
        chk("t2_pads", 64'({ts_link_pad, ts_lane_pad}), 64'h3);
        chk("t2_cnt", 64'(ts_consec_cnt), 64'd1);

        // 3: TS1 with bubbles between every symbol
        send_ts(8'h00, 1'b0, 8'h03, 1'b0, 8'h4A, 2, 0, 8'h00);
        after_ts("t3_pulse", 1'b1);
        chk("t3_lane", 64'(ts_lane), 64'h03);
        chk("t3_cnt", 64'(ts_consec_cnt), 64'd1);
        bub(2);

        // 4: TS1 with symbol 9 = TS2 identifier
        base = n_err;
        send_ts(8'h00, 1'b0, 8'h03, 1'b0, 8'h4A, 0, 9, 8'h45);
        after_ts("t4_nopulse", 1'b0);
        chk("t4_err", 64'(n_err - base), 64'd1);
        chk("t4_cnt", 64'(ts_consec_cnt), 64'd0);

        // 5: SKP OS then TS1
        base = n_skp;
        sym(8'hBC, 1'b1);
        repeat (3) sym(8'h1C, 1'b1);
        send_ts(8'h00, 1'b0, 8'h03, 1'b0, 8'h4A, 0, 0, 8'h00);
        after_ts("t5_pulse", 1'b1);
        chk("t5_skp", 64'(n_skp - base), 64'd1);
        chk("t5_cnt", 64'(ts_consec_cnt), 64'd1);

        // 6: EIOS, then elec idle in the middle of a TS, then saturation
        base = n_eios;
        sym(8'hBC, 1'b1);
        repeat (3) sym(8'h7C, 1'b1);
        bub(1);
        chk("t6_eios", 64'(n_eios - base), 64'd1);
        base = n_err;
        sym(8'hBC, 1'b1);
        sym(8'h00, 1'b0);
        sym(8'h03, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; in_elec_idle = 1'b1;
        @(negedge clk);
        in_elec_idle = 1'b0;
        bub(1);
        chk("t6_noerr", 64'(n_err - base), 64'd0);
        chk("t6_cnt0", 64'(ts_consec_cnt), 64'd0);
        chk("t6_hold", 64'(ts_lane), 64'h03);
        for (int n = 0; n < 17; n++) begin
            send_ts(8'h00, 1'b0, 8'h03, 1'b0, 8'h4A, 0, 0, 8'h00);
            after_ts("t6_pulse", 1'b1);
        end
        chk("t6_sat", 64'(ts_consec_cnt), 64'd15);

        // 7: wrong generation discards the TS and the run
        GEN = 3'd2;
        send_ts(8'h00, 1'b0, 8'h03, 1'b0, 8'h4A, 0, 0, 8'h00);
        after_ts("t7_nopulse", 1'b0);
        chk("t7_cnt", 64'(ts_consec_cnt), 64'd0);
        GEN = 3'd1;
        bub(1);

        // 8: reset asserted mid-OS
        sym(8'hBC, 1'b1);
        sym(8'h05, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("t8_async_link", 64'(ts_link), 64'd0);
        bub(2);
        reset = 1'b1;
        send_ts(8'h00, 1'b0, 8'h03, 1'b0, 8'h4A, 0, 0, 8'h00);
        after_ts("t8_pulse", 1'b1);
        chk("t8_cnt", 64'(ts_consec_cnt), 64'd1);
        bub(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
